sipo_deserializer: RTL

//   Serial-in, parallel-out receiver: the receive end of our parallel-load serial shifter link.

---
 rtl/sipo_deserializer.sv | 91 +++++++++
 1 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver with held output word,
// valid/ready handoff and sticky overrun on dropped words.
module sipo_deserializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       sin,
   input  logic                       sin_valid,
   input  logic                       clear,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic [WIDTH-1:0]           shadow,
   output logic [$clog2(WIDTH)-1:0]   bit_cnt,
   output logic                       busy,
   output logic                       overrun
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic [WIDTH-1:0] shift_w;
   logic             done_w;

   always_comb begin
      if (MSB_FIRST) shift_w = {shadow_q[WIDTH-2:0], sin};
      else           shift_w = {sin, shadow_q[WIDTH-1:1]};
   end

   assign done_w = sin_valid && !clear && (cnt_q == LAST);

   always_comb begin
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      valid_d  = valid_q;
      ovr_d    = ovr_q;

      if (clear) begin
         shadow_d = '0;
         cnt_d    = '0;
         ovr_d    = 1'b0;
      end else if (sin_valid) begin
         shadow_d = shift_w;
         cnt_d    = done_w ? '0 : cnt_q + 1'b1;
      end

      if (valid_q && dout_ready) valid_d = 1'b0;

      // A completion may replace a word that is being consumed on this edge
      if (done_w) begin
         if (!valid_q || dout_ready) begin
            dout_d  = shift_w;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign shadow     = shadow_q;
   assign bit_cnt    = cnt_q;
   assign busy       = (cnt_q != '0);
   assign overrun    = ovr_q;

endmodule
